// File: rtl/fpu_pkg.sv
// Shared types and constants for the Add_Sub post-adder normalize/round path.
// Field positions are offsets into the {carry, significand, G, R, S} word.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_POST  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_t;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;

    localparam int S_POS   = 0;
    localparam int R_POS   = 1;
    localparam int G_POS   = 2;
    localparam int LSB_POS = 3;

    // Carry and hidden bit sit above the significand, so they depend on MANT_W.
    function automatic int carry_bit(input int mant_w);
        return mant_w + 3;
    endfunction

    function automatic int hidden_bit(input int mant_w);
        return mant_w + 2;
    endfunction

    function automatic int exp_all_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    localparam int EXP_MAX = (1 << EXP_W_DEF) - 1;
    localparam int BIAS    = (1 << (EXP_W_DEF - 1)) - 1;

endpackage

// File: rtl/round_normalizer_if.sv
// Producer/consumer bundle for round_normalizer; the rmode field exists only
// when ROUND_MODE_EN is defined.
interface round_normalizer_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid and its payload hold until then.
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W+3:0] in_mant;
`ifdef ROUND_MODE_EN
    logic [1:0]        rmode;
`endif
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-2:0] out_frac;
    logic              out_overflow;
    logic              out_underflow;
    logic              out_zero;
    logic              out_inexact;

    modport slave (
`ifdef ROUND_MODE_EN
        input  rmode,
`endif
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac,
        output out_overflow, out_underflow, out_zero, out_inexact
    );

    modport master (
`ifdef ROUND_MODE_EN
        output rmode,
`endif
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac,
        input  out_overflow, out_underflow, out_zero, out_inexact
    );

endinterface

// File: rtl/round_incr.sv
// Rounding increment: adds the round-up bit to the significand and exposes
// the carry-out so the POST stage can renormalize.
module round_incr #(
    parameter int W = 24
) (
    input  logic         round,
    input  logic [W-1:0] sig,
    output logic [W-1:0] sum,
    output logic         carry
);

    assign {carry, sum} = {1'b0, sig} + (W + 1)'(round);

endmodule

// File: rtl/round_normalizer.sv
// Sequential normalize-and-round unit: one shift per cycle, valid/ready on both
// sides. Define ROUND_MODE_EN to add the rmode input (directed rounding modes).
module round_normalizer
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    round_normalizer_if.slave bus,
    output state_t            dbg_state
);

    localparam int MW     = MANT_W + 4;
    localparam int XW     = EXP_W + 2;
    localparam int CARRY  = carry_bit(MANT_W);
    localparam int HIDDEN = hidden_bit(MANT_W);
    localparam logic signed [XW-1:0] EXP_ONES = XW'(exp_all_ones(EXP_W));

    state_t                 state, next_state;
    logic [MW-1:0]          mant_q;
    logic signed [XW-1:0]   exp_q;
    logic                   sign_q;
    logic [MANT_W:0]        rsum_q;
    logic                   inexact_q;
`ifdef ROUND_MODE_EN
    rmode_t                 rmode_q;
`endif

    logic g, r, s, lsb, norm_shift, round_up;
    logic [MANT_W-1:0] incr_sum;
    logic incr_carry;

    assign g   = mant_q[G_POS];
    assign r   = mant_q[R_POS];
    assign s   = mant_q[S_POS];
    assign lsb = mant_q[LSB_POS];

    // Left shifts stop at exp==1 so a tiny value ends up as a subnormal.
    assign norm_shift = !mant_q[HIDDEN] && (|mant_q[HIDDEN-1:0]) && (exp_q > 1);

    always_comb begin
        round_up = g & (r | s | lsb);
`ifdef ROUND_MODE_EN
        case (rmode_q)
            RM_RTZ:  round_up = 1'b0;
            RM_RUP:  round_up = ~sign_q & (g | r | s);
            RM_RDN:  round_up = sign_q & (g | r | s);
            default: round_up = g & (r | s | lsb);
        endcase
`endif
    end

    round_incr #(.W(MANT_W)) u_round_incr (
        .round (round_up),
        .sig   (mant_q[HIDDEN:LSB_POS]),
        .sum   (incr_sum),
        .carry (incr_carry)
    );

    // Final packing computed from the rounded sum while in POST.
    logic [MANT_W-1:0]    post_sig;
    logic signed [XW-1:0] post_exp;
    logic [EXP_W-1:0]     post_efield;
    logic [MANT_W-2:0]    post_frac;
    logic                 post_ovf, post_unf, post_zero, post_inx;

    always_comb begin
        post_sig    = rsum_q[MANT_W] ? rsum_q[MANT_W:1] : rsum_q[MANT_W-1:0];
        post_exp    = exp_q + XW'(rsum_q[MANT_W]);
        post_efield = post_exp[EXP_W-1:0];
        post_frac   = post_sig[MANT_W-2:0];
        post_ovf    = 1'b0;
        post_unf    = 1'b0;
        post_zero   = 1'b0;
        post_inx    = inexact_q;
        if (!post_sig[MANT_W-1]) begin
            post_efield = '0;
            post_unf    = inexact_q;
        end else if (post_exp >= EXP_ONES) begin
            post_ovf    = 1'b1;
            post_efield = '1;
            post_frac   = '0;
`ifdef ROUND_MODE_EN
            if ((rmode_q == RM_RTZ) || (rmode_q == RM_RUP && sign_q) ||
                (rmode_q == RM_RDN && !sign_q)) begin
                post_efield = EXP_W'(exp_all_ones(EXP_W) - 1);
                post_frac   = '1;
            end
`endif
        end
        if (mant_q == '0) begin
            post_zero   = 1'b1;
            post_efield = '0;
            post_frac   = '0;
            post_inx    = 1'b0;
            post_unf    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.in_valid) next_state = ST_PRE;
            ST_PRE:   next_state = ST_NORM;
            ST_NORM:  if (!norm_shift) next_state = ST_ROUND;
            ST_ROUND: next_state = ST_POST;
            ST_POST:  next_state = ST_DONE;
            ST_DONE:  if (bus.out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    assign bus.in_ready = (state == ST_IDLE);
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_q            <= '0;
            exp_q             <= '0;
            sign_q            <= 1'b0;
            rsum_q            <= '0;
            inexact_q         <= 1'b0;
`ifdef ROUND_MODE_EN
            rmode_q           <= RM_RNE;
`endif
            bus.out_valid     <= 1'b0;
            bus.out_sign      <= 1'b0;
            bus.out_exp       <= '0;
            bus.out_frac      <= '0;
            bus.out_overflow  <= 1'b0;
            bus.out_underflow <= 1'b0;
            bus.out_zero      <= 1'b0;
            bus.out_inexact   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    mant_q <= bus.in_mant;
                    exp_q  <= {2'b00, bus.in_exp};
                    sign_q <= bus.in_sign;
`ifdef ROUND_MODE_EN
                    rmode_q <= rmode_t'(bus.rmode);
`endif
                end
                ST_PRE: if (mant_q[CARRY]) begin
                    mant_q <= {1'b0, mant_q[MW-1:2], mant_q[R_POS] | mant_q[S_POS]};
                    exp_q  <= exp_q + XW'(1);
                end
                ST_NORM: if (norm_shift) begin
                    // G feeds the LSB, R->G, S->R, and S keeps its sticky value.
                    mant_q <= {1'b0, mant_q[HIDDEN-1:LSB_POS], g, r, s, s};
                    exp_q  <= exp_q - XW'(1);
                end
                ST_ROUND: begin
                    rsum_q    <= {incr_carry, incr_sum};
                    inexact_q <= g | r | s;
                end
                ST_POST: begin
                    bus.out_valid     <= 1'b1;
                    bus.out_sign      <= sign_q;
                    bus.out_exp       <= post_efield;
                    bus.out_frac      <= post_frac;
                    bus.out_overflow  <= post_ovf;
                    bus.out_underflow <= post_unf;
                    bus.out_zero      <= post_zero;
                    bus.out_inexact   <= post_inx;
                end
                ST_DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_normalizer.sv
// Scoreboard bench for round_normalizer with MANT_W=24, EXP_W=8, RNE rounding.
module tb_round_normalizer;
    import fpu_pkg::*;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    round_normalizer_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

    round_normalizer #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [35:0] pack(input logic sg, input logic [7:0] e, input logic [22:0] f,
                                         input logic ovf, input logic unf, input logic zr, input logic inx);
        return {sg, e, f, ovf, unf, zr, inx};
    endfunction

    function automatic logic [35:0] observed();
        return {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_overflow,
                bus.out_underflow, bus.out_zero, bus.out_inexact};
    endfunction

    // Drives one operand, waits (bounded) for the result, checks it and latency,
    // holds out_ready low briefly to confirm stability, then drains.
    task automatic run_op(input string tag, input logic sg, input logic [7:0] e,
                          input logic [27:0] m, input logic [35:0] want, input int lat);
        int cyc;
        logic [35:0] item;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        exp_q.push_back(want);
        bus.in_valid = 1'b1;
        bus.in_sign  = sg;
        bus.in_exp   = e;
        bus.in_mant  = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check({tag, "_busy"}, 64'(bus.in_ready), 64'(0));
        end
        item = exp_q.pop_front();
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 64'(bus.out_valid), 64'(1));
        end else begin
            check({tag, "_result"}, 64'(observed()), 64'(item));
            if (lat >= 0) check({tag, "_latency"}, 64'(cyc), 64'(lat));
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_hold"}, 64'({bus.out_valid, observed()}), 64'({1'b1, item}));
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check({tag, "_drained"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
        end
    endtask

    initial begin
        logic        sg;
        logic [7:0]  e;
        logic [22:0] f;
        logic [2:0]  grs;
        logic [24:0] sum;
        logic [7:0]  ee;
        logic        up;

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b0;
`ifdef ROUND_MODE_EN
        bus.rmode     = 2'b00;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({bus.out_valid, observed()}), 64'(0));
        check("reset_ready", 64'(bus.in_ready), 64'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("normalized",   1'b0, 8'h80, 28'h4000000, pack(0, 8'h80, 23'h0, 0, 0, 0, 0), 4);
        run_op("carry_tie",    1'b0, 8'h80, 28'h8000008, pack(0, 8'h81, 23'h0, 0, 0, 0, 1), 4);
        run_op("round_carry",  1'b0, 8'h80, 28'h7FFFFFC, pack(0, 8'h81, 23'h0, 0, 0, 0, 1), 4);
        run_op("shift23",      1'b0, 8'h80, 28'h0000008, pack(0, 8'h69, 23'h0, 0, 0, 0, 0), 27);
        run_op("overflow",     1'b0, 8'hFE, 28'h8000000, pack(0, 8'(EXP_MAX), 23'h0, 1, 0, 0, 0), 4);
        run_op("overflow_neg", 1'b1, 8'hFE, 28'h8000000, pack(1, 8'(EXP_MAX), 23'h0, 1, 0, 0, 0), 4);
        run_op("zero",         1'b0, 8'h80, 28'h0000000, pack(0, 8'h00, 23'h0, 0, 0, 1, 0), 4);
        run_op("zero_neg",     1'b1, 8'h80, 28'h0000000, pack(1, 8'h00, 23'h0, 0, 0, 1, 0), 4);
        run_op("tie_odd_up",   1'b0, 8'h80, 28'h400000C, pack(0, 8'h80, 23'h2, 0, 0, 0, 1), 4);
        run_op("rs_only",      1'b1, 8'h80, 28'h4000003, pack(1, 8'h80, 23'h0, 0, 0, 0, 1), 4);
        run_op("exp_floor",    1'b0, 8'h03, 28'h1000004, pack(0, 8'h01, 23'h2, 0, 0, 0, 0), 6);
        run_op("subnormal",    1'b0, 8'h01, 28'h1000006, pack(0, 8'h00, 23'h200001, 0, 1, 0, 1), 4);

        // Abort in the middle of a long normalization.
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 8'h80;
        bus.in_mant  = 28'h0000008;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_in_norm", 64'(dbg_state), 64'(ST_NORM));
        rst = 1'b1;
        #1;
        check("abort_cleared", 64'({bus.in_ready, bus.out_valid, observed()}), 64'({2'b10, 36'h0}));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("after_abort", 1'b0, 8'h80, 28'h4000000, pack(0, 8'h80, 23'h0, 0, 0, 0, 0), 4);

        // Random normalized operands against an integer rounding model.
        for (int i = 0; i < 16; i++) begin
            sg  = 1'($urandom_range(0, 1));
            e   = 8'($urandom_range(BIAS - 100, BIAS + 100));
            f   = 23'($urandom_range(0, (1 << 23) - 1));
            grs = 3'($urandom_range(0, 7));
            up  = (grs > 3'd4) || (grs == 3'd4 && f[0]);
            sum = {2'b01, f} + 25'(up);
            ee  = sum[24] ? e + 8'd1 : e;
            run_op($sformatf("rand%0d", i), sg, e, {2'b01, f, grs},
                   pack(sg, ee, sum[24] ? 23'h0 : sum[22:0], 0, 0, 0, grs != 3'd0), 4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/round_normalizer.md
# round_normalizer

Post-adder normalize-and-round unit for the Add_Sub datapath. It consumes the raw sum from the mantissa adder and drives the rounding increment. It then absorbs the increment's carry-out (the rounding overflow) by renormalizing and bumping the exponent. The operation is sequential: one shift per cycle, with a valid/ready handshake on both sides.

## Interface
- MANT_W, 24, significand width including hidden bit
- EXP_W, 8, biased exponent width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  high only in IDLE
- in_sign  input  1  result sign, passed through
- in_exp  input  EXP_W  biased exponent of raw sum
- in_mant  input  MANT_W+4  {carry, significand[MANT_W-1:0] with hidden bit at the top, G, R, S}
- out_valid  output  1  result held until out_ready
- out_ready  input  1  consumer accepts
- out_sign/out_exp/out_frac  output  1/EXP_W/MANT_W-1  IEEE-style packed result
- out_overflow, out_underflow, out_zero, out_inexact  output  1 each  status flags

## Operation
- States: IDLE, PRE, NORM, ROUND, POST, DONE. All outputs reset to 0. Reset enters IDLE with in_ready=1.
- IDLE: when in_valid, register all inputs and go to PRE. The internal exponent is signed, EXP_W+2 bits wide.
- PRE: if carry=1, shift the significand right by 1, OR the shifted-out bit into S, and add 1 to the exponent. Go to NORM.
- NORM, evaluated once per cycle:
  - If the hidden bit is 0, the significand/GRS is nonzero, and exp>1: shift left by 1 (G moves into the LSB, S stays sticky) and subtract 1 from the exponent.
  - Otherwise, go to ROUND.
- ROUND: default mode is round-to-nearest-even, up = G & (R | S | LSB). Add up to the MANT_W-bit significand, producing an MANT_W+1-bit sum. Set inexact = G|R|S.
- POST:
  - If the sum carries out, shift it right by 1 and add 1 to the exponent.
  - If the hidden bit is 0 after rounding, set the exponent to 0 (subnormal) and set out_underflow = inexact.
  - If the exponent is ≥ 2^EXP_W−1, set out_overflow=1, exp to all ones, and frac to 0.
  - If the significand and GRS are all zero, set out_zero=1, exp=0, frac=0, inexact=0.
  - Load the outputs and go to DONE.
- DONE: out_valid=1 and outputs are stable. On out_ready, go to IDLE, dropping out_valid the following cycle.
- Sign is never altered, including for zero and infinity.
- The input is not accepted while busy (in_ready=0 outside IDLE).

## Timing
- k = number of left shifts performed, 0 ≤ k ≤ MANT_W+2.
- out_valid rises k+4 rising edges after the accepting edge. Exactly 4 when no left shift is needed.
- NORM occupies k+1 cycles. PRE, ROUND, and POST take 1 cycle each.
- Minimum spacing between accepts is k+6 cycles: a DONE cycle with out_ready=1, then one IDLE cycle.
- Asserting rst in any state aborts the operation immediately. The partial result is discarded and the flags are cleared.
- out_ready held low: DONE holds indefinitely and the outputs do not change.

## Configuration
- ROUND_MODE_EN defined: adds input rmode[1:0], sampled with in_valid:
  - 00 = RNE
  - 01 = toward zero (up=0)
  - 10 = toward +inf (up = ~sign & (G|R|S))
  - 11 = toward −inf (up = sign & (G|R|S))
  - Overflow under the directed modes saturates to the max finite value (exp all ones minus 1, frac all ones) where IEEE requires it.
- Not defined: no rmode port; RNE only.

## Structure
- Shared package fpu_pkg:
  - state enum
  - rounding-mode encodings
  - EXP_MAX/bias constants
  - in_mant field index constants (CARRY_BIT, HIDDEN_BIT, G/R/S positions)
- One natural sub-module: round_incr. It is the combinational increment-with-carry taking {round, significand} and returning {sum, carry}. POST consumes its carry.

## Test plan
All cases use MANT_W=24, EXP_W=8.
- in_exp=0x80, in_mant=28'h4000000 -> out_exp=0x80, frac=0, inexact=0, out_valid 4 cycles after accept.
- in_exp=0x80, in_mant=28'h8000008 (carry, RNE tie, LSB even) -> out_exp=0x81, frac=0, inexact=1, no round-up.
- in_exp=0x80, in_mant=28'h7FFFFFC (all ones, G=1) -> rounding carry, out_exp=0x81, frac=0, inexact=1.
- in_exp=0x80, in_mant=28'h0000008 -> 23 shifts, out_exp=0x69, frac=0, out_valid 27 cycles after accept.
- in_exp=0xFE, in_mant=28'h8000000 -> out_overflow=1, exp=0xFF, frac=0. Separately, in_mant=0 -> out_zero=1, exp=0.
- Accept in_mant=28'h0000008, assert rst during NORM -> next cycle in_ready=1, out_valid=0, all flags 0. A following normal operation completes correctly.
